// File: rtl/csr_seq_pkg.sv
// Shared types and constants for the CSR read-modify-write sequencer.
// Holds the FSM state encoding, Zicsr op codes and the fixed FP CSR addresses.
package csr_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] OP_RW = 2'd1;
  localparam logic [1:0] OP_RS = 2'd2;
  localparam logic [1:0] OP_RC = 2'd3;

  localparam logic [11:0] FFLAGS_SEL = 12'h001;
  localparam logic [11:0] FRM_SEL    = 12'h002;
  localparam logic [11:0] FCSR_SEL   = 12'h003;

  // Zicsr reserves the top two address bits == 2'b11 for read-only CSRs.
  function automatic logic is_read_only(input logic [1:0] sel_hi);
    return (sel_hi == 2'b11);
  endfunction

endpackage

// File: rtl/csr_rr_arbiter.sv
// Two-way round-robin arbiter between core CSR instructions and FPU flag accrual.
// Grants only while enabled; remembers the last winner to alternate under contention.
module csr_rr_arbiter (
  input  logic CLK,
  input  logic RESET,
  input  logic i_enable,
  input  logic i_core_valid,
  input  logic i_fpu_valid,
  output logic o_grant_core,
  output logic o_grant_fpu
);

  logic r_last_fpu;
  logic w_grant_core;
  logic w_grant_fpu;

  // Last grant starts as core, so the FPU wins the first contended cycle.
  assign w_grant_fpu  = i_enable & i_fpu_valid & (~i_core_valid | ~r_last_fpu);
  assign w_grant_core = i_enable & i_core_valid & ~w_grant_fpu;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_last_fpu <= 1'b0;
    end else if (w_grant_fpu) begin
      r_last_fpu <= 1'b1;
    end else if (w_grant_core) begin
      r_last_fpu <= 1'b0;
    end
  end

  assign o_grant_core = w_grant_core;
  assign o_grant_fpu  = w_grant_fpu;

endmodule

// File: rtl/csr_access_sequencer.sv
// Atomic read-modify-write sequencer in front of the CSR register file.
// One access in flight: IDLE -> READ -> WRITE -> (RESP for core | IDLE for FPU).
module csr_access_sequencer #(
  parameter int                    CSR_SEL_W  = 12,
  parameter int                    XLEN       = 32,
  parameter logic [CSR_SEL_W-1:0] FFLAGS_SEL = csr_seq_pkg::FFLAGS_SEL
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 in_core_req_valid,
  output logic                 out_core_req_ready,
  input  logic [1:0]           in_core_req_op,
  input  logic [CSR_SEL_W-1:0] in_core_req_select,
  input  logic [XLEN-1:0]      in_core_req_operand,
  output logic                 out_core_resp_valid,
  input  logic                 in_core_resp_ready,
  output logic [XLEN-1:0]      out_core_resp_data,
  output logic                 out_core_resp_illegal,
  input  logic                 in_fpu_req_valid,
  output logic                 out_fpu_req_ready,
  input  logic [4:0]           in_fpu_req_flags,
  output logic [CSR_SEL_W-1:0] out_csr_read_select,
  input  logic [XLEN-1:0]      in_csr_read_data,
  output logic                 out_csr_write_enable,
  output logic [CSR_SEL_W-1:0] out_csr_write_select,
  output logic [XLEN-1:0]      out_csr_write_data
);

  import csr_seq_pkg::*;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [1:0]           r_op;
  logic [CSR_SEL_W-1:0] r_sel;
  logic [XLEN-1:0]      r_operand;
  logic                 r_is_fpu;
  logic [XLEN-1:0]      r_old_val;
  logic                 r_illegal;

  logic                 w_arb_enable;
  logic                 w_grant_core;
  logic                 w_grant_fpu;
  logic                 w_write_wanted;
  logic                 w_illegal;
  logic [XLEN-1:0]      w_new_val;

  assign w_arb_enable = RESET & (r_state == ST_IDLE);

  csr_rr_arbiter u_arb (
    .CLK          (CLK),
    .RESET        (RESET),
    .i_enable     (w_arb_enable),
    .i_core_valid (in_core_req_valid),
    .i_fpu_valid  (in_fpu_req_valid),
    .o_grant_core (w_grant_core),
    .o_grant_fpu  (w_grant_fpu)
  );

  assign out_core_req_ready = w_grant_core;
  assign out_fpu_req_ready  = w_grant_fpu;

  // Op 0 is reserved: behaves as a set that never writes.
  assign w_write_wanted = (r_op == OP_RW) | ((r_op != 2'd0) & (r_operand != '0));
  assign w_illegal      = w_write_wanted & is_read_only(r_sel[CSR_SEL_W-1 -: 2]);

  always_comb begin
    w_new_val = r_old_val | r_operand;
    case (r_op)
      OP_RW:   w_new_val = r_operand;
      OP_RC:   w_new_val = r_old_val & ~r_operand;
      default: w_new_val = r_old_val | r_operand;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt           = r_state;
    out_csr_read_select   = '0;
    out_csr_write_enable  = 1'b0;
    out_csr_write_select  = '0;
    out_csr_write_data    = '0;
    out_core_resp_valid   = 1'b0;
    out_core_resp_data    = '0;
    out_core_resp_illegal = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_core || w_grant_fpu) begin
          w_state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        out_csr_read_select = r_sel;
        w_state_nxt         = ST_WRITE;
      end
      ST_WRITE: begin
        out_csr_write_enable = w_write_wanted & ~w_illegal;
        out_csr_write_select = r_sel;
        out_csr_write_data   = w_new_val;
        w_state_nxt          = r_is_fpu ? ST_IDLE : ST_RESP;
      end
      ST_RESP: begin
        out_core_resp_valid   = 1'b1;
        out_core_resp_data    = r_old_val;
        out_core_resp_illegal = r_illegal;
        if (in_core_resp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FPU accrual is folded into a set of the zero-extended flags on fflags.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_op      <= 2'd0;
      r_sel     <= '0;
      r_operand <= '0;
      r_is_fpu  <= 1'b0;
      r_old_val <= '0;
      r_illegal <= 1'b0;
    end else begin
      if (w_grant_fpu) begin
        r_op      <= OP_RS;
        r_sel     <= FFLAGS_SEL;
        r_operand <= {{(XLEN-5){1'b0}}, in_fpu_req_flags};
        r_is_fpu  <= 1'b1;
      end else if (w_grant_core) begin
        r_op      <= in_core_req_op;
        r_sel     <= in_core_req_select;
        r_operand <= in_core_req_operand;
        r_is_fpu  <= 1'b0;
      end
      if (r_state == ST_READ) begin
        r_old_val <= in_csr_read_data;
      end
      if (r_state == ST_WRITE) begin
        r_illegal <= w_illegal;
      end
    end
  end

endmodule

// File: tb/tb_csr_access_sequencer.sv
// Directed scoreboard bench for csr_access_sequencer with a behavioural CSR file.
// Expected writes and responses are queued at acceptance and checked when they appear.
module tb_csr_access_sequencer;

  import csr_seq_pkg::*;

  typedef struct {
    logic [11:0] sel;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  typedef struct {
    logic [31:0] data;
    logic        ill;
    int          cyc;
  } rs_t;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        in_core_req_valid;
  logic        out_core_req_ready;
  logic [1:0]  in_core_req_op;
  logic [11:0] in_core_req_select;
  logic [31:0] in_core_req_operand;
  logic        out_core_resp_valid;
  logic        in_core_resp_ready;
  logic [31:0] out_core_resp_data;
  logic        out_core_resp_illegal;
  logic        in_fpu_req_valid;
  logic        out_fpu_req_ready;
  logic [4:0]  in_fpu_req_flags;
  logic [11:0] out_csr_read_select;
  logic [31:0] in_csr_read_data;
  logic        out_csr_write_enable;
  logic [11:0] out_csr_write_select;
  logic [31:0] out_csr_write_data;

  bit   [31:0] mem [4096];
  logic        tb_pre_we = 1'b0;
  logic [11:0] tb_pre_sel = '0;
  logic [31:0] tb_pre_data = '0;

  int  cyc = 0;
  int  n_pass = 0;
  int  n_total = 0;
  wr_t wq[$];
  rs_t rq[$];

  always #5 CLK = ~CLK;

  csr_access_sequencer dut (
    .CLK                   (CLK),
    .RESET                 (RESET),
    .in_core_req_valid     (in_core_req_valid),
    .out_core_req_ready    (out_core_req_ready),
    .in_core_req_op        (in_core_req_op),
    .in_core_req_select    (in_core_req_select),
    .in_core_req_operand   (in_core_req_operand),
    .out_core_resp_valid   (out_core_resp_valid),
    .in_core_resp_ready    (in_core_resp_ready),
    .out_core_resp_data    (out_core_resp_data),
    .out_core_resp_illegal (out_core_resp_illegal),
    .in_fpu_req_valid      (in_fpu_req_valid),
    .out_fpu_req_ready     (out_fpu_req_ready),
    .in_fpu_req_flags      (in_fpu_req_flags),
    .out_csr_read_select   (out_csr_read_select),
    .in_csr_read_data      (in_csr_read_data),
    .out_csr_write_enable  (out_csr_write_enable),
    .out_csr_write_select  (out_csr_write_select),
    .out_csr_write_data    (out_csr_write_data)
  );

  assign in_csr_read_data = mem[out_csr_read_select];

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (out_csr_write_enable) mem[out_csr_write_select] <= out_csr_write_data;
    else if (tb_pre_we)       mem[tb_pre_sel] <= tb_pre_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  always @(negedge CLK) begin
    if (RESET && out_csr_write_enable) begin
      if (wq.size() == 0) begin
        chk("write_expected", wq.size(), 1);
      end else begin
        wr_t w;
        w = wq.pop_front();
        chk("write_sel", out_csr_write_select, w.sel);
        chk("write_data", out_csr_write_data, w.data);
        chk("write_cycle", cyc, w.cyc);
      end
    end
  end

  task automatic preload(input logic [11:0] sel, input logic [31:0] data);
    tb_pre_sel  = sel;
    tb_pre_data = data;
    tb_pre_we   = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    tb_pre_we   = 1'b0;
  endtask

  task automatic core_req(input logic [1:0] op, input logic [11:0] sel, input logic [31:0] operand,
                          input bit do_wr, input logic [31:0] wdata,
                          input bit do_resp, input logic [31:0] rdata, input logic ill,
                          output int acc);
    in_core_req_valid   = 1'b1;
    in_core_req_op      = op;
    in_core_req_select  = sel;
    in_core_req_operand = operand;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (out_core_req_ready) break;
      @(negedge CLK);
    end
    chk("core_req_ready", out_core_req_ready, 1);
    @(posedge CLK);
    #1 acc = cyc;
    if (do_wr)   wq.push_back('{sel: sel, data: wdata, cyc: acc + 1});
    if (do_resp) rq.push_back('{data: rdata, ill: ill, cyc: acc + 2});
    @(negedge CLK);
    in_core_req_valid = 1'b0;
  endtask

  task automatic fpu_req(input logic [4:0] flags, input bit do_wr, input logic [31:0] wdata);
    int acc;
    in_fpu_req_valid = 1'b1;
    in_fpu_req_flags = flags;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (out_fpu_req_ready) break;
      @(negedge CLK);
    end
    chk("fpu_req_ready", out_fpu_req_ready, 1);
    @(posedge CLK);
    #1 acc = cyc;
    if (do_wr) wq.push_back('{sel: FFLAGS_SEL, data: wdata, cyc: acc + 1});
    @(negedge CLK);
    in_fpu_req_valid = 1'b0;
  endtask

  task automatic resp_wait_check();
    rs_t r;
    for (int i = 0; i < 20; i++) begin
      if (out_core_resp_valid) break;
      @(negedge CLK);
    end
    chk("resp_seen", out_core_resp_valid, 1);
    if (rq.size() == 0) begin
      chk("resp_expected", rq.size(), 1);
    end else begin
      r = rq.pop_front();
      chk("resp_data", out_core_resp_data, r.data);
      chk("resp_illegal", out_core_resp_illegal, r.ill);
      chk("resp_cycle", cyc, r.cyc);
    end
  endtask

  task automatic resp_ack();
    in_core_resp_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    in_core_resp_ready = 1'b0;
  endtask

  initial begin
    int acc_f;
    int acc_c;
    RESET               = 1'b0;
    in_core_req_valid   = 1'b0;
    in_core_req_op      = 2'd0;
    in_core_req_select  = '0;
    in_core_req_operand = '0;
    in_core_resp_ready  = 1'b0;
    in_fpu_req_valid    = 1'b0;
    in_fpu_req_flags    = '0;

    @(negedge CLK);
    preload(12'h340, 32'h11);

    // Reset state with both requesters already pending.
    in_fpu_req_valid    = 1'b1;
    in_fpu_req_flags    = 5'h05;
    in_core_req_valid   = 1'b1;
    in_core_req_op      = OP_RW;
    in_core_req_select  = 12'h340;
    in_core_req_operand = 32'hDEADBEEF;
    #1;
    chk("rst_core_ready", out_core_req_ready, 0);
    chk("rst_fpu_ready", out_fpu_req_ready, 0);
    chk("rst_write_en", out_csr_write_enable, 0);
    chk("rst_resp_valid", out_core_resp_valid, 0);
    chk("rst_read_sel", out_csr_read_select, 0);
    chk("rst_write_sel", out_csr_write_select, 0);
    chk("rst_write_data", out_csr_write_data, 0);
    chk("rst_resp_data", out_core_resp_data, 0);

    @(negedge CLK);
    RESET = 1'b1;
    #1;
    chk("arb_fpu_first", out_fpu_req_ready, 1);
    chk("arb_core_waits", out_core_req_ready, 0);
    @(posedge CLK);
    #1 acc_f = cyc;
    wq.push_back('{sel: FFLAGS_SEL, data: 32'h5, cyc: acc_f + 1});
    @(negedge CLK);
    in_fpu_req_valid = 1'b0;
    in_fpu_req_flags = '0;
    core_req(OP_RW, 12'h340, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1, 32'h11, 0, acc_c);
    chk("arb_core_next_idle", acc_c, acc_f + 3);
    resp_wait_check();
    resp_ack();
    chk("fflags_after_fpu", mem[12'h001], 32'h5);

    // Set with zero operand must not write.
    core_req(OP_RS, 12'h001, 32'h0, 0, 32'h0, 1, 32'h5, 0, acc_c);
    resp_wait_check();
    resp_ack();

    preload(12'h001, 32'h1F);
    core_req(OP_RC, 12'h001, 32'h3, 1, 32'h1C, 1, 32'h1F, 0, acc_c);
    resp_wait_check();
    resp_ack();

    // Write attempt to a read-only CSR.
    preload(12'hC00, 32'hABCD);
    core_req(OP_RW, 12'hC00, 32'h1, 0, 32'h0, 1, 32'hABCD, 1, acc_c);
    resp_wait_check();
    resp_ack();
    chk("ro_unchanged", mem[12'hC00], 32'hABCD);

    // Response back-pressure with an FPU request waiting.
    core_req(OP_RS, 12'h340, 32'h100, 1, 32'hDEADBFEF, 1, 32'hDEADBEEF, 0, acc_c);
    resp_wait_check();
    in_fpu_req_valid = 1'b1;
    in_fpu_req_flags = 5'h02;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      chk("bp_resp_valid", out_core_resp_valid, 1);
      chk("bp_resp_data", out_core_resp_data, 32'hDEADBEEF);
      chk("bp_core_ready", out_core_req_ready, 0);
      chk("bp_fpu_ready", out_fpu_req_ready, 0);
    end
    resp_ack();
    fpu_req(5'h02, 1, 32'h1E);
    fpu_req(5'h00, 0, 32'h0);
    repeat (3) @(negedge CLK);
    chk("fflags_accrued", mem[12'h001], 32'h1E);

    // Asynchronous reset in the middle of the WRITE cycle.
    core_req(OP_RW, 12'h340, 32'h5555, 0, 32'h0, 0, 32'h0, 0, acc_c);
    @(posedge CLK);
    #2;
    chk("pre_rst_write_en", out_csr_write_enable, 1);
    chk("pre_rst_write_data", out_csr_write_data, 32'h5555);
    #1 RESET = 1'b0;
    #1;
    chk("async_rst_write_en", out_csr_write_enable, 0);
    chk("async_rst_write_data", out_csr_write_data, 0);
    @(negedge CLK);
    RESET = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk("rst_no_resp", out_core_resp_valid, 0);
    end
    chk("rst_write_dropped", mem[12'h340], 32'hDEADBFEF);
    core_req(OP_RW, 12'h340, 32'h77, 1, 32'h77, 1, 32'hDEADBFEF, 0, acc_c);
    resp_wait_check();
    resp_ack();
    chk("post_rst_write", mem[12'h340], 32'h77);

    chk("wq_drained", wq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
